// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// pwm_capture
//
// Measures the period (rising-to-rising) and high time (rising-to-falling) of
// an asynchronous PWM input, in clk cycles.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous, active-low reset
//   en       in   measurement enable (synchronous); low forces IDLE
//   wave_in  in   PWM input, asynchronous to clk
//   period   out  [15:0] latched rising-to-rising interval
//   high     out  [15:0] latched rising-to-falling interval
//   valid    out  one-cycle pulse, period/high updated in that cycle
//   timeout  out  sticky: no rising edge seen within 65535 cycles
//   locked   out  high while the FSM is in MEAS
//
// Output handshake: valid is a single-cycle strobe with no ready/back-pressure.
// period and high change only in the cycle where valid is high and hold their
// value at all other times, so a consumer may sample them on valid or later.
// ---------------------------------------------------------------------------
module pwm_capture (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        wave_in,
    output logic [15:0] period,
    output logic [15:0] high,
    output logic        valid,
    output logic        timeout,
    output logic        locked
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_t;

    state_t      state;
    logic        s1;
    logic        s2;
    logic        s3;
    logic        rise;
    logic        fall;
    logic [15:0] cnt;
    logic [15:0] high_lat;

    // Two-flop synchronizer (s1, s2) plus a history flop (s3) for edge detect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= wave_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // s2 and s3 cannot both differ in two directions at once, so rise and
    // fall are mutually exclusive.
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    // Measurement FSM. locked is registered alongside the state so it always
    // equals (state == MEAS).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 16'd0;
            high_lat <= 16'd0;
            period   <= 16'd0;
            high     <= 16'd0;
            valid    <= 1'b0;
            timeout  <= 1'b0;
            locked   <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!en) begin
                // Disable wins over any edge in the same cycle; the partial
                // measurement is dropped but the last result is kept.
                state    <= IDLE;
                cnt      <= 16'd0;
                high_lat <= 16'd0;
                timeout  <= 1'b0;
                locked   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ARM;
                    end
                    ARM: begin
                        // First rise is only a reference point: no capture.
                        if (rise) begin
                            state  <= MEAS;
                            cnt    <= 16'd1;
                            locked <= 1'b1;
                        end
                    end
                    MEAS: begin
                        if (rise) begin
                            period  <= cnt;
                            high    <= high_lat;
                            valid   <= 1'b1;
                            timeout <= 1'b0;
                            cnt     <= 16'd1;
                        end else begin
                            if (fall) begin
                                high_lat <= cnt;
                            end
                            // Counter reached its ceiling without a new rise:
                            // give up on this reference and re-arm.
                            if (cnt == 16'hFFFF) begin
                                timeout <= 1'b1;
                                state   <= ARM;
                                locked  <= 1'b0;
                            end else begin
                                cnt <= cnt + 16'd1;
                            end
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// ---------------------------------------------------------------------------
// tb_pwm_capture
//
// Drives pwm_capture with waveform tables built from (level, length) segments
// and compares every cycle against a reference model that derives expected
// results from the timing of the input edges: an input edge driven in cycle k
// is acted on at clock edge k+2 and becomes visible one cycle later; the
// period is the distance between acted rises, the high time is the distance
// from a rise to the following fall.
// ---------------------------------------------------------------------------
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        wave_in;
    logic [15:0] period;
    logic [15:0] high;
    logic        valid;
    logic        timeout;
    logic        locked;

    int errors = 0;
    int checks = 0;
    int gcyc   = 0;
    int last_ref = -1;

    logic [15:0] hold_p = 16'd0;
    logic [15:0] hold_h = 16'd0;

    bit          w_q[$];
    bit          en_q[$];
    logic [31:0] exp_q[$];

    pwm_capture dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .wave_in (wave_in),
        .period  (period),
        .high    (high),
        .valid   (valid),
        .timeout (timeout),
        .locked  (locked)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic add_seg(input bit lvl, input int len);
        for (int i = 0; i < len; i++) begin
            w_q.push_back(lvl);
            en_q.push_back(1'b1);
        end
    endtask

    function automatic bit wv(input int j);
        if (j < 0) return 1'b0;
        if (j < w_q.size()) return w_q[j];
        return w_q[w_q.size() - 1];
    endfunction

    function automatic bit env(input int j);
        if (j < en_q.size()) return en_q[j];
        return en_q[en_q.size() - 1];
    endfunction

    // Called at a falling edge; leaves the DUT in ARM with a quiet input.
    task automatic prologue();
        for (int i = 0; i < 5; i++) begin
            en = 1'b0; wave_in = 1'b0;
            @(negedge clk); gcyc++;
        end
        for (int i = 0; i < 2; i++) begin
            en = 1'b1; wave_in = 1'b0;
            @(negedge clk); gcyc++;
        end
    endtask

    // Plays w_q/en_q (one entry per cycle) and checks all outputs every cycle.
    // Called at a falling edge; returns at a falling edge.
    task automatic play_wave(input string name, input bit init_armed,
                             input bit init_locked, input bit init_tmo);
        int n, m, base, rf, lf;
        bit armed, lk, tmo, ve, r_e, f_e;
        logic [15:0] p, h;
        bit ev[], el[], et[];
        logic [15:0] ep[], eh[];
        logic [31:0] got, want;

        n = w_q.size();
        m = n + 4;
        ev = new[m + 1]; el = new[m + 1]; et = new[m + 1];
        ep = new[m + 1]; eh = new[m + 1];

        // Reference model, indexed by clock edge e; results visible at e+1.
        armed = init_armed; lk = init_locked; tmo = init_tmo;
        rf = -1; lf = -1; p = hold_p; h = hold_h;
        ev[0] = 1'b0; el[0] = lk; et[0] = tmo; ep[0] = p; eh[0] = h;
        for (int e = 0; e < m; e++) begin
            ve  = 1'b0;
            r_e = wv(e - 2) && !wv(e - 3);
            f_e = !wv(e - 2) && wv(e - 3);
            if (!env(e)) begin
                armed = 1'b0; rf = -1; lk = 1'b0; tmo = 1'b0;
            end else if (!armed) begin
                armed = 1'b1;
            end else if (r_e) begin
                if (rf >= 0) begin
                    ve  = 1'b1;
                    p   = 16'(e - rf);
                    h   = 16'(lf - rf);
                    tmo = 1'b0;
                end
                rf = e;
                lk = 1'b1;
            end else if (f_e) begin
                lf = e;
            end
            ev[e + 1] = ve; el[e + 1] = lk; et[e + 1] = tmo;
            ep[e + 1] = p;  eh[e + 1] = h;
        end

        base = gcyc;
        for (int i = 0; i <= m; i++) begin
            if (ev[i]) exp_q.push_back({ep[i], eh[i]});

            checks++;
            if (valid !== ev[i]) begin
                errors++;
                $display("FAIL %s valid @%0d: got %b exp %b", name, i, valid, ev[i]);
            end
            checks++;
            if (locked !== el[i]) begin
                errors++;
                $display("FAIL %s locked @%0d: got %b exp %b", name, i, locked, el[i]);
            end
            checks++;
            if (timeout !== et[i]) begin
                errors++;
                $display("FAIL %s timeout @%0d: got %b exp %b", name, i, timeout, et[i]);
            end
            checks++;
            if (period !== ep[i]) begin
                errors++;
                $display("FAIL %s period @%0d: got %0d exp %0d", name, i, period, ep[i]);
            end
            checks++;
            if (high !== eh[i]) begin
                errors++;
                $display("FAIL %s high @%0d: got %0d exp %0d", name, i, high, eh[i]);
            end

            // Scoreboard: each observed pulse consumes one expected capture.
            if (valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s capture @%0d: got %0d/%0d exp none", name, i, period, high);
                end else begin
                    want = exp_q.pop_front();
                    got  = {period, high};
                    if (got !== want) begin
                        errors++;
                        $display("FAIL %s capture @%0d: got %0d/%0d exp %0d/%0d",
                                 name, i, period, high, want[31:16], want[15:0]);
                    end
                end
            end

            if (i < m) begin
                wave_in = wv(i);
                en      = env(i);
                @(negedge clk);
                gcyc++;
            end
        end

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s missing captures: got 0 exp %0d more", name, exp_q.size());
        end
        exp_q.delete();
        if (rf >= 0) last_ref = base + rf;
        hold_p = p;
        hold_h = h;
        w_q.delete();
        en_q.delete();
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (period !== 16'd0) begin errors++; $display("FAIL %s period: got %0d exp 0", name, period); end
        checks++;
        if (high !== 16'd0) begin errors++; $display("FAIL %s high: got %0d exp 0", name, high); end
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL %s valid: got %b exp 0", name, valid); end
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL %s timeout: got %b exp 0", name, timeout); end
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL %s locked: got %b exp 0", name, locked); end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; en = 1'b0; wave_in = 1'b0;
        #1 rst = 1'b0;
        #1 check_all_zero("reset_async");
        repeat (3) @(negedge clk);
        check_all_zero("reset_held");
        rst = 1'b1;
        hold_p = 16'd0; hold_h = 16'd0;
    endtask

    task automatic test_basic();
        prologue();
        for (int k = 0; k < 6; k++) begin add_seg(1'b1, 4); add_seg(1'b0, 6); end
        play_wave("basic_4_6", 1'b1, 1'b0, 1'b0);
        checks++;
        if (period !== 16'd10 || high !== 16'd4) begin
            errors++;
            $display("FAIL basic_final: got %0d/%0d exp 10/4", period, high);
        end
    endtask

    task automatic test_period_change();
        prologue();
        for (int k = 0; k < 4; k++) begin add_seg(1'b1, 4);  add_seg(1'b0, 6); end
        for (int k = 0; k < 3; k++) begin add_seg(1'b1, 15); add_seg(1'b0, 5); end
        add_seg(1'b1, 2);
        play_wave("period_change", 1'b1, 1'b0, 1'b0);
        checks++;
        if (period !== 16'd20 || high !== 16'd15) begin
            errors++;
            $display("FAIL period_change_final: got %0d/%0d exp 20/15", period, high);
        end
    endtask

    task automatic test_min_wave();
        prologue();
        for (int k = 0; k < 12; k++) begin add_seg(1'b1, 1); add_seg(1'b0, 1); end
        play_wave("min_wave", 1'b1, 1'b0, 1'b0);
        checks++;
        if (period !== 16'd2 || high !== 16'd1) begin
            errors++;
            $display("FAIL min_wave_final: got %0d/%0d exp 2/1", period, high);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            prologue();
            for (int k = 0; k < 15; k++) begin
                add_seg(1'b1, $urandom_range(1, 20));
                add_seg(1'b0, $urandom_range(1, 20));
            end
            add_seg(1'b1, 1);
            play_wave($sformatf("random_%0d", r), 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_en_drop();
        prologue();
        for (int k = 0; k < 4; k++) begin add_seg(1'b1, 4); add_seg(1'b0, 6); end
        // Rise driven at index 30 is acted on at edge 32: drop en exactly there.
        en_q[32] = 1'b0;
        for (int k = 0; k < 4; k++) begin add_seg(1'b1, 4); add_seg(1'b0, 6); end
        play_wave("en_drop", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        int found;
        bit saw_valid;
        prologue();
        for (int k = 0; k < 3; k++) begin add_seg(1'b1, 4); add_seg(1'b0, 6); end
        play_wave("timeout_lock", 1'b1, 1'b0, 1'b0);

        found = -1;
        saw_valid = 1'b0;
        for (int c = 0; c < 70000; c++) begin
            if (timeout === 1'b1) begin
                found = gcyc;
                break;
            end
            if (valid === 1'b1) saw_valid = 1'b1;
            wave_in = 1'b0;
            @(negedge clk);
            gcyc++;
        end
        checks++;
        if (found != last_ref + 65536) begin
            errors++;
            $display("FAIL timeout_cycle: got %0d exp %0d", found - last_ref, 65536);
        end
        checks++;
        if (saw_valid) begin
            errors++;
            $display("FAIL timeout_no_valid: got 1 exp 0");
        end
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL timeout_locked: got %b exp 0", locked);
        end
        checks++;
        if (period !== 16'd10 || high !== 16'd4) begin
            errors++;
            $display("FAIL timeout_hold: got %0d/%0d exp 10/4", period, high);
        end

        add_seg(1'b0, 2);
        add_seg(1'b1, 3); add_seg(1'b0, 5);
        add_seg(1'b1, 3); add_seg(1'b0, 5);
        play_wave("after_timeout", 1'b1, 1'b0, 1'b1);
        checks++;
        if (period !== 16'd8 || high !== 16'd3 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL after_timeout_final: got %0d/%0d t=%b exp 8/3 t=0", period, high, timeout);
        end
    endtask

    task automatic test_reset_mid();
        prologue();
        for (int k = 0; k < 3; k++) begin add_seg(1'b1, 4); add_seg(1'b0, 6); end
        add_seg(1'b1, 2);
        play_wave("pre_reset", 1'b1, 1'b0, 1'b0);
        // wave_in is high here and stays high through reset.
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_all_zero("reset_mid_async");
        @(negedge clk); gcyc++;
        @(negedge clk); gcyc++;
        rst = 1'b1;
        hold_p = 16'd0; hold_h = 16'd0;
        add_seg(1'b1, 3); add_seg(1'b0, 6);
        for (int k = 0; k < 3; k++) begin add_seg(1'b1, 4); add_seg(1'b0, 6); end
        play_wave("post_reset", 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- main ----------------
    initial begin
        test_reset();
        test_basic();
        test_period_change();
        test_min_wave();
        test_random();
        test_en_drop();
        test_reset_mid();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, named clk and rst.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  measurement enable, synchronous to clk.
- wave_in  in  1  PWM input, asynchronous to clk.
- period  out  16  latched rising-to-rising interval, in clk cycles.
- high  out  16  latched rising-to-falling interval, in clk cycles.
- valid  out  1  one-cycle pulse; period and high updated this cycle.
- timeout  out  1  sticky flag; no rising edge seen within 65535 cycles.
- locked  out  1  high while in state MEAS.

Function
REQ-003 wave_in SHALL pass through a 2-flop synchronizer (s1, s2) followed by a history flop s3.
REQ-004 Edges SHALL be derived from the synchronized signal: rise = s2 & ~s3, fall = ~s2 & s3.
REQ-005 The FSM SHALL have three states: IDLE, ARM and MEAS.
REQ-006 IDLE -> ARM when en = 1. Any state -> IDLE on any cycle with en = 0. en = 0 SHALL take priority over all edges in the same cycle.
REQ-007 ARM -> MEAS on rise. On that cycle cnt SHALL load 1, and valid SHALL NOT assert (no prior reference edge).
REQ-008 In MEAS, a 16-bit counter cnt SHALL increment by 1 every cycle without rise. cnt SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-009 In MEAS, on fall, high_lat SHALL load cnt.
- cnt = number of cycles since the rise cycle.
REQ-010 In MEAS, on rise, the following SHALL happen on the next clock edge:
- period <= cnt
- high <= high_lat
- valid = 1 for exactly one cycle
- cnt <= 1
- timeout <= 0
REQ-011 rise and fall are mutually exclusive by construction; no simultaneous-edge case exists.
REQ-012 Latency: valid SHALL be high in the cycle following the 3rd clk rising edge after wave_in's rising transition is first sampled by s1. This is a fixed 3-cycle pipeline.
REQ-013 If cnt = 16'hFFFF in MEAS with no rise, the block SHALL:
- set timeout = 1,
- go to ARM,
- leave period and high unchanged,
- not pulse valid.
This covers a constant-high or constant-low input.
REQ-014 timeout SHALL remain set until the next valid pulse or en = 0.
REQ-015 period and high SHALL hold their last values at all times other than a valid cycle, including in IDLE and ARM.
REQ-016 high SHALL always be < period for any valid pulse.
REQ-017 A capture with high_lat never loaded since the last rise is impossible, because each rise requires a preceding fall.
REQ-018 locked SHALL equal (state == MEAS).

Reset
REQ-019 While rst = 0, the following SHALL be cleared asynchronously to zero: s1, s2, s3, cnt, high_lat, period, high, valid, timeout, locked. The state SHALL be IDLE.
REQ-020 After rst deasserts, no edge SHALL be reported until the synchronizer has refilled.
- A wave_in held at 1 through reset SHALL produce one rise (s2 = 1, s3 = 0) only after ARM is entered.
- That rise is handled per REQ-007.
REQ-021 rst asserted mid-measurement SHALL discard the partial measurement. The first valid after re-enable SHALL require two rises.
REQ-022 en = 0 mid-measurement SHALL have the same effect on cnt, high_lat and the state as reset. It SHALL NOT clear period or high.

Verification
REQ-023 Reset, then en = 1, then a periodic wave with 4 cycles high and 6 low -> first valid on the second rise with period = 10 and high = 4. Thereafter valid pulses every 10 cycles, locked = 1, timeout = 0.
REQ-024 Period changes from 10 (high 4) to 20 (high 15) mid-stream -> one valid reports 10/4, the next valid reports 20/15, with no intermediate value.
REQ-025 wave_in held low for 70000 cycles after lock -> timeout = 1 at cnt = 65535, state ARM, period and high unchanged. The next two rises 8 cycles apart (high 3) -> valid with period = 8, high = 3, timeout = 0.
REQ-026 en = 0 for 1 cycle coincident with a rise, then en = 1 -> no valid on that rise, state IDLE then ARM. The first valid arrives on the second subsequent rise.
REQ-027 rst pulsed low mid-high-phase -> all outputs 0 asynchronously, without waiting for clk. After release, the rise is counted only per REQ-020 and REQ-021.
REQ-028 Minimum wave (1 cycle high, 1 cycle low, period 2) -> valid every 2 cycles with period = 2, high = 1.
